char_bbox_detect: RTL and testbench
===================================

# char_bbox_detect

Bounding-box extractor for the binarized character video stream. It sits directly upstream of the character-recognition stage. It watches the same Y/HSync/VSync/VDE stream and tracks the minimum and maximum column and row of foreground pixels (Y=1) across one frame. At frame end it latches the box onto x_min1/x_max1/y_min1/y_max1 for the recognizer to use during the next frame.

## Interface
- H_ACTIVE, 1280, active pixels per line; column counter range 0..H_ACTIVE-1
- V_ACTIVE, 720, active lines per frame; row counter range 0..V_ACTIVE-1
- MIN_PIXELS, 16, minimum foreground pixel count for a frame's box to be accepted
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Y  in  1  binarized pixel (1 = foreground)
- HSync  in  1  line signal, active high; pixels are sampled only while HSync=1
- VSync  in  1  field signal, active high; high = vertical blanking
- VDE  in  1  data valid, active high
- x_min1  out  13  latched left column of box
- x_max1  out  13  latched right column of box
- y_min1  out  13  latched top row of box
- y_max1  out  13  latched bottom row of box
- box_found  out  1  level; 1 = latched box came from a frame with ≥ MIN_PIXELS foreground pixels
- box_valid  out  1  one-cycle pulse when outputs are updated at frame end
- pix_count  out  21  foreground pixel count of the last completed frame (saturating)

## Operation
- Pixel qualifier: `pix = HSync & VDE & ~VSync`.
- Column counter `xc` (13b):
  - increments on each `pix` cycle
  - clears on the VDE falling edge (registered `VDE_d=1`, `VDE=0`)
  - saturates at H_ACTIVE-1
- Row counter `yc` (13b):
  - increments on each VDE falling edge, saturating at V_ACTIVE
  - clears while VSync=1
- Pixels with `yc ≥ V_ACTIVE` are ignored. Pixels arriving after `xc` has saturated are treated as column H_ACTIVE-1.
- Running trackers `rx_min`, `rx_max`, `ry_min`, `ry_max`, `rcnt`:
  - On `pix & Y`: `rx_min=min(rx_min,xc)`, `rx_max=max(rx_max,xc)`, `ry_min=min(ry_min,yc)`, `ry_max=max(ry_max,yc)`, `rcnt++`.
  - `rcnt` saturates at 2^21-1.
  - Comparisons are unsigned 13-bit.
  - Tracker init values: `rx_min=H_ACTIVE-1`, `ry_min=V_ACTIVE-1`, `rx_max=0`, `ry_max=0`, `rcnt=0`.
- Frame FSM, states IDLE, ARMED, SCAN:
  - IDLE (after reset) → ARMED on the first VSync=1 cycle.
  - ARMED → SCAN on the VSync falling edge; trackers load their init values on that edge.
  - SCAN → ARMED on the VSync rising edge (frame end), with the latch action below.
- Latch action on the SCAN→ARMED transition:
  - `pix_count <= rcnt`, `box_valid <= 1` for one cycle.
  - If `rcnt ≥ MIN_PIXELS`: `x_min1/x_max1/y_min1/y_max1 <= trackers`, `box_found <= 1`.
  - Otherwise: box outputs hold their previous values, `box_found <= 0`.
- Partial frames: a frame is latched only if SCAN was entered through a VSync falling edge. A reset mid-frame therefore never produces a latch for that partial frame.
- Simultaneous VSync rise and `pix & Y`: VSync wins; that pixel is not counted (`pix` is 0 by definition).

## Timing
- Reset values:
  - x_min1, x_max1, y_min1, y_max1 = 0
  - box_found = 0, box_valid = 0, pix_count = 0
  - FSM = IDLE, counters = 0
- VSync and VDE are registered once for edge detection. Edge-triggered actions occur on the clock edge after the input transition is first sampled.
- Tracker update: the result is visible one cycle after the qualifying pixel.
- Latch: outputs change 1 cycle after the VSync rising edge is first sampled (VSync=1 & VSync_d=0). box_valid is high in that same cycle only.
- Outputs are stable from latch until the next frame-end latch. The downstream recognizer sees a constant box for the whole following frame.
- Reset asserted at any time forces all reset values immediately (asynchronous). Deassertion is taken synchronously to clk.

## Test plan
- Solid rectangle, Y=1 for columns 600..680 and rows 200..500 of a 1280x720 frame → at frame end, box_valid pulses once; x_min1=600, x_max1=680, y_min1=200, y_max1=500, box_found=1, pix_count=81*301=24381.
- All-zero frame following the rectangle frame → box_valid pulses; box_found=0, pix_count=0; box outputs still 600/680/200/500.
- 10 isolated foreground pixels (below MIN_PIXELS=16) → box_found=0, pix_count=10, box outputs unchanged.
- Single foreground pixels at the four corners (0,0), (1279,0), (0,719), (1279,719) plus a 16-pixel blob → x_min1=0, x_max1=1279, y_min1=0, y_max1=719.
- rst_n pulsed low at row 300 of a frame containing a box → all outputs 0 immediately; no box_valid at that frame's end. The next full frame latches correctly.
- Two back-to-back frames with boxes (100..199, 50..149) then (900..950, 400..600) → two box_valid pulses, one per frame end, each carrying its own frame's box; no carry-over of min/max values between frames.

Source files
------------

// File: rtl/char_bbox_detect.sv
// Tracks the min/max column and row of foreground pixels over a frame and latches
// the box at frame end (VSync rise); the latched box holds for the following frame.
module char_bbox_detect #(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Y,
  input  logic        HSync,
  input  logic        VSync,
  input  logic        VDE,
  output logic [12:0] x_min1,
  output logic [12:0] x_max1,
  output logic [12:0] y_min1,
  output logic [12:0] y_max1,
  output logic        box_found,
  output logic        box_valid,
  output logic [20:0] pix_count
);

  localparam logic [12:0] X_LAST  = 13'(H_ACTIVE - 1);
  localparam logic [12:0] Y_LAST  = 13'(V_ACTIVE - 1);
  localparam logic [12:0] Y_END   = 13'(V_ACTIVE);
  localparam logic [20:0] CNT_MAX = '1;
  localparam logic [20:0] MIN_CNT = 21'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, ARMED, SCAN} state_t;

  state_t      state, state_nxt;
  logic        vsync_d, vde_d;
  logic [12:0] xc, yc;
  logic [12:0] rx_min, rx_max, ry_min, ry_max;
  logic [20:0] rcnt;
  logic        arm_init, do_latch;

  logic pix, hit, vs_rise, vs_fall, vde_fall;
  assign pix      = HSync & VDE & ~VSync;
  assign hit      = pix & Y & (yc < Y_END);
  assign vs_rise  = VSync & ~vsync_d;
  assign vs_fall  = ~VSync & vsync_d;
  assign vde_fall = ~VDE & vde_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vsync_d <= 1'b0;
      vde_d   <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_d <= VSync;
      vde_d   <= VDE;
    end
  end

  // A latch is only possible from SCAN, which is reachable only via a VSync fall,
  // so a frame cut by reset never gets latched.
  always_comb begin
    state_nxt = state;
    arm_init  = 1'b0;
    do_latch  = 1'b0;
    case (state)
      IDLE:  if (VSync) state_nxt = ARMED;
      ARMED: if (vs_fall) begin
               state_nxt = SCAN;
               arm_init  = 1'b1;
             end
      SCAN:  if (vs_rise) begin
               state_nxt = ARMED;
               do_latch  = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xc <= '0;
      yc <= '0;
    end else begin
      if (vde_fall)
        xc <= '0;
      else if (pix && xc != X_LAST)
        xc <= xc + 13'd1;
      if (VSync)
        yc <= '0;
      else if (vde_fall && yc != Y_END)
        yc <= yc + 13'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_min <= X_LAST;
      rx_max <= '0;
      ry_min <= Y_LAST;
      ry_max <= '0;
      rcnt   <= '0;
    end else if (arm_init) begin
      rx_min <= X_LAST;
      rx_max <= '0;
      ry_min <= Y_LAST;
      ry_max <= '0;
      rcnt   <= '0;
    end else if (hit) begin
      if (xc < rx_min) rx_min <= xc;
      if (xc > rx_max) rx_max <= xc;
      if (yc < ry_min) ry_min <= yc;
      if (yc > ry_max) ry_max <= yc;
      if (rcnt != CNT_MAX) rcnt <= rcnt + 21'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_min1    <= '0;
      x_max1    <= '0;
      y_min1    <= '0;
      y_max1    <= '0;
      box_found <= 1'b0;
      box_valid <= 1'b0;
      pix_count <= '0;
    end else begin
      box_valid <= do_latch;
      if (do_latch) begin
        pix_count <= rcnt;
        box_found <= (rcnt >= MIN_CNT);
        // Sparse frames keep the previous box so the recognizer is not fed noise.
        if (rcnt >= MIN_CNT) begin
          x_min1 <= rx_min;
          x_max1 <= rx_max;
          y_min1 <= ry_min;
          y_max1 <= ry_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_char_bbox_detect.sv
// Bench for char_bbox_detect: full-width frames with short-row rectangles, scoreboard of latched boxes.
module tb_char_bbox_detect;

  logic        clk = 1'b0;
  logic        rst_n, Y, HSync, VSync, VDE;
  logic [12:0] x_min1, x_max1, y_min1, y_max1;
  logic        box_found, box_valid;
  logic [20:0] pix_count;

  always #5 clk = ~clk;

  char_bbox_detect dut (
    .clk(clk), .rst_n(rst_n), .Y(Y), .HSync(HSync), .VSync(VSync), .VDE(VDE),
    .x_min1(x_min1), .x_max1(x_max1), .y_min1(y_min1), .y_max1(y_max1),
    .box_found(box_found), .box_valid(box_valid), .pix_count(pix_count)
  );

  typedef struct {int x0; int x1; int y0; int y1;} rect_t;
  typedef struct {int xmn; int xmx; int ymn; int ymx; int found; int cnt;} exp_t;

  rect_t rects[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    nvalid = 0;

  function automatic bit fg(input int x, input int y);
    foreach (rects[i])
      if (x >= rects[i].x0 && x <= rects[i].x1 && y >= rects[i].y0 && y <= rects[i].y1)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input logic yv, input logic hs, input logic vs, input logic de);
    @(negedge clk);
    Y = yv; HSync = hs; VSync = vs; VDE = de;
  endtask

  // Rows without foreground are a single VDE cycle; others run to the rightmost pixel.
  task automatic lines(input int r0, input int r1);
    for (int r = r0; r < r1; r++) begin
      int len;
      len = 0;
      foreach (rects[i])
        if (r >= rects[i].y0 && r <= rects[i].y1 && rects[i].x1 + 1 > len)
          len = rects[i].x1 + 1;
      if (len == 0)
        drive(1'b0, 1'b0, 1'b0, 1'b1);
      else
        for (int x = 0; x < len; x++) drive(fg(x, r), 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic vblank();
    repeat (4) drive(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && box_valid === 1'b1) begin
        nvalid++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_box_valid got pulse want none");
        end else begin
          e = sb.pop_front();
          checks += 6;
          if (x_min1 !== 13'(e.xmn)) begin errors++; $display("FAIL x_min1 got %0d want %0d", x_min1, e.xmn); end
          if (x_max1 !== 13'(e.xmx)) begin errors++; $display("FAIL x_max1 got %0d want %0d", x_max1, e.xmx); end
          if (y_min1 !== 13'(e.ymn)) begin errors++; $display("FAIL y_min1 got %0d want %0d", y_min1, e.ymn); end
          if (y_max1 !== 13'(e.ymx)) begin errors++; $display("FAIL y_max1 got %0d want %0d", y_max1, e.ymx); end
          if (box_found !== 1'(e.found)) begin errors++; $display("FAIL box_found got %0d want %0d", box_found, e.found); end
          if (pix_count !== 21'(e.cnt)) begin errors++; $display("FAIL pix_count got %0d want %0d", pix_count, e.cnt); end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Y = 1'b0; HSync = 1'b0; VSync = 1'b0; VDE = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (x_min1 !== 13'd0)    begin errors++; $display("FAIL reset_x_min1 got %0d want 0", x_min1); end
    if (x_max1 !== 13'd0)    begin errors++; $display("FAIL reset_x_max1 got %0d want 0", x_max1); end
    if (y_min1 !== 13'd0)    begin errors++; $display("FAIL reset_y_min1 got %0d want 0", y_min1); end
    if (y_max1 !== 13'd0)    begin errors++; $display("FAIL reset_y_max1 got %0d want 0", y_max1); end
    if (box_found !== 1'b0)  begin errors++; $display("FAIL reset_box_found got %0d want 0", box_found); end
    if (box_valid !== 1'b0)  begin errors++; $display("FAIL reset_box_valid got %0d want 0", box_valid); end
    if (pix_count !== 21'd0) begin errors++; $display("FAIL reset_pix_count got %0d want 0", pix_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_rect();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    rects.push_back(rect_t'{600, 680, 200, 215});
    sb.push_back(exp_t'{600, 680, 200, 215, 1, 81 * 16});
    lines(0, 720);
    vblank();
    checks += 2;
    if (nvalid !== nv0 + 1) begin errors++; $display("FAIL rect_pulses got %0d want 1", nvalid - nv0); end
    if (box_valid !== 1'b0) begin errors++; $display("FAIL rect_pulse_width got %0d want 0", box_valid); end
  endtask

  task automatic test_zero();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    sb.push_back(exp_t'{600, 680, 200, 215, 0, 0});
    lines(0, 720);
    vblank();
    checks++;
    if (nvalid !== nv0 + 1) begin errors++; $display("FAIL zero_pulses got %0d want 1", nvalid - nv0); end
  endtask

  task automatic test_few();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    for (int i = 0; i < 10; i++) rects.push_back(rect_t'{5 + 7 * i, 5 + 7 * i, 300 + i, 300 + i});
    sb.push_back(exp_t'{600, 680, 200, 215, 0, 10});
    lines(0, 720);
    vblank();
    checks++;
    if (nvalid !== nv0 + 1) begin errors++; $display("FAIL few_pulses got %0d want 1", nvalid - nv0); end
  endtask

  task automatic test_corners();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    rects.push_back(rect_t'{0, 0, 0, 0});
    rects.push_back(rect_t'{1279, 1279, 0, 0});
    rects.push_back(rect_t'{0, 0, 719, 719});
    rects.push_back(rect_t'{1279, 1279, 719, 719});
    rects.push_back(rect_t'{500, 515, 360, 360});
    sb.push_back(exp_t'{0, 1279, 0, 719, 1, 20});
    lines(0, 720);
    vblank();
    checks++;
    if (nvalid !== nv0 + 1) begin errors++; $display("FAIL corner_pulses got %0d want 1", nvalid - nv0); end
  endtask

  // Pixel past column 1279 reads as 1279; pixel on a row beyond the frame is dropped.
  task automatic test_saturation();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    rects.push_back(rect_t'{10, 25, 5, 5});
    rects.push_back(rect_t'{1400, 1400, 6, 6});
    rects.push_back(rect_t'{0, 0, 721, 721});
    sb.push_back(exp_t'{10, 1279, 5, 6, 1, 17});
    lines(0, 722);
    vblank();
    checks++;
    if (nvalid !== nv0 + 1) begin errors++; $display("FAIL sat_pulses got %0d want 1", nvalid - nv0); end
  endtask

  task automatic test_reset_mid();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    rects.push_back(rect_t'{100, 120, 290, 310});
    lines(0, 300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (x_min1 !== 13'd0)    begin errors++; $display("FAIL midrst_x_min1 got %0d want 0", x_min1); end
    if (x_max1 !== 13'd0)    begin errors++; $display("FAIL midrst_x_max1 got %0d want 0", x_max1); end
    if (y_min1 !== 13'd0)    begin errors++; $display("FAIL midrst_y_min1 got %0d want 0", y_min1); end
    if (y_max1 !== 13'd0)    begin errors++; $display("FAIL midrst_y_max1 got %0d want 0", y_max1); end
    if (box_found !== 1'b0)  begin errors++; $display("FAIL midrst_box_found got %0d want 0", box_found); end
    if (box_valid !== 1'b0)  begin errors++; $display("FAIL midrst_box_valid got %0d want 0", box_valid); end
    if (pix_count !== 21'd0) begin errors++; $display("FAIL midrst_pix_count got %0d want 0", pix_count); end
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    lines(300, 720);
    vblank();
    checks += 2;
    if (nvalid !== nv0)      begin errors++; $display("FAIL midrst_pulses got %0d want 0", nvalid - nv0); end
    if (x_max1 !== 13'd0)    begin errors++; $display("FAIL midrst_hold_x_max1 got %0d want 0", x_max1); end
  endtask

  task automatic test_back_to_back();
    int nv0;
    nv0 = nvalid;
    rects.delete();
    rects.push_back(rect_t'{100, 199, 50, 59});
    sb.push_back(exp_t'{100, 199, 50, 59, 1, 1000});
    lines(0, 720);
    vblank();
    rects.delete();
    rects.push_back(rect_t'{900, 950, 400, 409});
    sb.push_back(exp_t'{900, 950, 400, 409, 1, 510});
    lines(0, 720);
    vblank();
    checks += 2;
    if (nvalid !== nv0 + 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", nvalid - nv0); end
    if (sb.size() !== 0)    begin errors++; $display("FAIL b2b_pending got %0d want 0", sb.size()); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    vblank();
    test_rect();
    test_zero();
    test_few();
    test_corners();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
